// File: rtl/key_cmd_pkg.sv
// Shared definitions for the keypad command controller: key width, the
// debounce FSM state type and the maze direction codes used by consumers.
package key_cmd_pkg;

  localparam int KEY_W = 4;

  // Maze direction keys on the 4x4 keypad
  localparam logic [KEY_W-1:0] KEY_UP    = 4'd1;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 4'd4;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 4'd6;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

endpackage

// File: rtl/key_cmd_fifo.sv
// Small command FIFO with extra-MSB pointers. A push into a full FIFO is
// dropped (signalled on drop) unless a pop happens in the same cycle. There
// is no fall-through: a pop request while empty is ignored. The head output
// keeps the last popped value while the FIFO is empty.
module key_cmd_fifo
  import key_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = KEY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Same index with differing MSB means the write pointer has lapped the read pointer
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? last : mem[rd_ptr[AW-1:0]];

  // Pointer and last-head bookkeeping; pointers wrap by natural overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Entry storage; only ever read while the slot holds a live entry
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keypad command controller: synchronises the scanner's key-valid/code pair,
// debounces presses and releases, and queues one command per confirmed press
// for the game logic. Build with KEY_CMD_REPEAT_EN defined to add auto-repeat
// while a key stays held; without it each press yields exactly one command.
module key_cmd_ctrl
  import key_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int DEPTH         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             cmd_ready,
  input  logic             clr_ovf,
  output logic             cmd_valid,
  output logic [KEY_W-1:0] cmd_code,
  output logic             key_held,
  output logic             overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // Reject configurations the counters and FIFO pointers cannot represent
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("key_cmd_ctrl: DEBOUNCE_CYC must be at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("key_cmd_ctrl: DEPTH must be a power of two, at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("key_cmd_ctrl: REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

`ifdef KEY_CMD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W = $clog2(RMAX + 1);
  localparam logic [RC_W-1:0] RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic [RC_W-1:0] rcnt;
  logic            rep_first;
`endif

  state_t           state;
  logic             v_meta;
  logic             v_s;
  logic [KEY_W-1:0] c_meta;
  logic [KEY_W-1:0] c_s;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             fifo_empty;
  logic             drop;

  // Two-flop synchroniser for the scanner's key-valid level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_meta <= 1'b0;
      v_s    <= 1'b0;
    end else begin
      v_meta <= key_valid;
      v_s    <= v_meta;
    end
  end

  // Two-flop synchroniser for the key code; only consulted while v_s is high
  always_ff @(posedge clk) begin
    c_meta <= key_code;
    c_s    <= c_meta;
  end

  // Debounce FSM; push and key_held are registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      push     <= 1'b0;
      key_held <= 1'b0;
`ifdef KEY_CMD_REPEAT_EN
      rcnt      <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: begin
          if (v_s) begin
            cand  <= c_s;
            cnt   <= '0;
            state <= DEB;
          end
        end
        DEB: begin
          if (!v_s || c_s != cand) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            push     <= 1'b1;
            key_held <= 1'b1;
            state    <= HELD;
`ifdef KEY_CMD_REPEAT_EN
            rcnt      <= '0;
            rep_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          // A code change mid-hold is a release: the new key must be pressed afresh
          if (!v_s || c_s != cand) begin
            cnt      <= '0;
            key_held <= 1'b0;
            state    <= REL;
`ifdef KEY_CMD_REPEAT_EN
            rcnt <= '0;
`endif
          end
`ifdef KEY_CMD_REPEAT_EN
          else if (rcnt == (rep_first ? RC_DELAY_LAST : RC_PERIOD_LAST)) begin
            push      <= 1'b1;
            rcnt      <= '0;
            rep_first <= 1'b0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
`endif
        end
        REL: begin
          // Any high sample restarts the release window; nothing is pushed here
          if (v_s) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  key_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (cand),
    .pop   (cmd_ready),
    .dout  (cmd_code),
    .empty (fifo_empty),
    .drop  (drop)
  );

  assign cmd_valid = !fifo_empty;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Bench for key_cmd_ctrl with short debounce/repeat timings. Expected commands
// and their handshake cycles come from a press-level model: a press seen for
// H cycles yields a command D+4 cycles after its first sample, plus repeats
// at fixed offsets when KEY_CMD_REPEAT_EN is defined.
module tb_key_cmd_ctrl;
  import key_cmd_pkg::*;

  localparam int D     = 4;
  localparam int RD    = 20;
  localparam int RP    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       cmd_ready;
  logic       clr_ovf;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       key_held;
  logic       overflow;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  int got_code[$];
  int got_edge[$];
  int exp_code[$];
  int exp_edge[$];

  key_cmd_ctrl #(
    .DEBOUNCE_CYC  (D),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .DEPTH         (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .cmd_ready (cmd_ready),
    .clr_ovf   (clr_ovf),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log each handshake with the clock edge at which it completes
  always @(negedge clk) begin
    if (reset === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      got_code.push_back(int'(cmd_code));
      got_edge.push_back(cyc + 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of commands from a stable press whose level is seen for hold cycles
  function automatic int n_events(input int hold);
    int n;
    if (hold < D + 1) return 0;
    n = 1;
`ifdef KEY_CMD_REPEAT_EN
    for (int r = RD; r <= hold - 1 - D; r += RP) n++;
`endif
    return n;
  endfunction

  function automatic int ev_off(input int k);
    if (k == 0) return 0;
    return RD + (k - 1) * RP;
  endfunction

  task automatic expect_press(input int code, input int hold, input int e0);
    int n;
    n = n_events(hold);
    for (int k = 0; k < n; k++) begin
      exp_code.push_back(code);
      exp_edge.push_back(e0 + D + 4 + ev_off(k));
    end
  endtask

  task automatic compare_log(input string tag, input bit with_edges);
    check({tag, ".count"}, got_code.size(), exp_code.size());
    for (int k = 0; k < exp_code.size(); k++) begin
      if (k < got_code.size()) begin
        check($sformatf("%s.code%0d", tag, k), got_code[k], exp_code[k]);
        if (with_edges)
          check($sformatf("%s.edge%0d", tag, k), got_edge[k], exp_edge[k]);
      end
    end
    got_code.delete(); got_edge.delete();
    exp_code.delete(); exp_edge.delete();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Entered at 1 time unit after a rising edge. Optionally pulses cmd_ready
  // or clr_ovf for exactly the cycle whose closing edge writes the FIFO.
  task automatic press(input logic [3:0] code, input int hold, input int gap,
                       input bit rdy_wr, input bit clr_wr,
                       output int e0, output int held);
    key_code  = code;
    key_valid = 1'b1;
    e0   = cyc + 1;
    held = 0;
    for (int i = 0; i < hold + gap; i++) begin
      @(posedge clk); #1;
      if (key_held === 1'b1) held++;
      if (i == hold - 1) key_valid = 1'b0;
      if (cyc == e0 + D + 2) begin
        if (rdy_wr) cmd_ready = 1'b1;
        if (clr_wr) clr_ovf = 1'b1;
      end
      if (cyc == e0 + D + 3) begin
        if (rdy_wr) cmd_ready = 1'b0;
        if (clr_wr) clr_ovf = 1'b0;
      end
    end
  endtask

  initial begin
    int e0;
    int held;
    int hold;
    int gap;
    logic [3:0] code;

    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    cmd_ready = 1'b1;
    clr_ovf   = 1'b0;

    // Reset state
    tick(3);
    check("rst.cmd_valid", cmd_valid, 0);
    check("rst.cmd_code",  cmd_code,  0);
    check("rst.key_held",  key_held,  0);
    check("rst.overflow",  overflow,  0);
    reset = 1'b1;
    tick(2);

    // Clean press of code 5 for 30 cycles, consumer always ready
    press(4'd5, 30, 10, 1'b0, 1'b0, e0, held);
    expect_press(5, 30, e0);
    check("clean.held_cycles", held, 30 - D);
    check("clean.valid_after", cmd_valid, 0);
    compare_log("clean", 1'b1);

    // Bounce: 2 high / 1 low, five times, never long enough to confirm
    key_code = 4'd7;
    for (int b = 0; b < 5; b++) begin
      key_valid = 1'b1; tick(2);
      key_valid = 1'b0; tick(1);
    end
    tick(12);
    check("bounce.overflow", overflow, 0);
    check("bounce.key_held", key_held, 0);
    check("bounce.valid",    cmd_valid, 0);
    compare_log("bounce", 1'b1);

    // Overflow: consumer stalled through five presses
    cmd_ready = 1'b0;
    press(KEY_UP,    10, 8, 1'b0, 1'b0, e0, held);
    press(KEY_LEFT,  10, 8, 1'b0, 1'b0, e0, held);
    press(KEY_RIGHT, 10, 8, 1'b0, 1'b0, e0, held);
    press(KEY_DOWN,  10, 8, 1'b0, 1'b0, e0, held);
    check("full.overflow_before", overflow, 0);
    press(4'd2,      10, 8, 1'b0, 1'b0, e0, held);
    check("ovf.overflow",  overflow,  1);
    check("ovf.cmd_valid", cmd_valid, 1);
    check("ovf.head",      cmd_code,  KEY_UP);
    // A drop in the same cycle as clr_ovf keeps the flag set
    press(4'd3, 10, 8, 1'b0, 1'b1, e0, held);
    check("ovf.set_wins", overflow, 1);
    clr_ovf = 1'b1; tick(1);
    clr_ovf = 1'b0;
    check("ovf.cleared", overflow, 0);
    // Push and pop together while full: both happen, no overflow
    press(4'd7, 10, 8, 1'b1, 1'b0, e0, held);
    check("fullpp.overflow", overflow, 0);
    check("fullpp.head",     cmd_code, KEY_LEFT);
    cmd_ready = 1'b1;
    tick(10);
    exp_code = '{1, 4, 6, 9, 7};
    check("drain.cmd_valid", cmd_valid, 0);
    check("drain.hold_last", cmd_code,  7);
    compare_log("drain", 1'b0);

    // Code changes from 6 to 9 mid-hold: counts as release, 9 needs a fresh press
    key_code = 4'd6; key_valid = 1'b1;
    e0 = cyc + 1;
    tick(15);
    key_code = 4'd9;
    tick(15);
    key_valid = 1'b0;
    tick(10);
    expect_press(6, 15, e0);
    exp_edge.delete();
    press(4'd9, 10, 10, 1'b0, 1'b0, e0, held);
    exp_code.push_back(9);
    compare_log("switch", 1'b0);

    // Reset mid-hold with a queued command, key still held afterwards
    cmd_ready = 1'b0;
    key_code = 4'd3; key_valid = 1'b1;
    e0 = cyc + 1;
    tick(D + 6);
    check("midrst.pre_valid", cmd_valid, 1);
    check("midrst.pre_held",  key_held,  1);
    reset = 1'b0;
    #1;
    check("midrst.cmd_valid", cmd_valid, 0);
    check("midrst.cmd_code",  cmd_code,  0);
    check("midrst.key_held",  key_held,  0);
    check("midrst.overflow",  overflow,  0);
    tick(2);
    reset = 1'b1;
    cmd_ready = 1'b1;
    e0 = cyc + 1;
    tick(15);
    key_valid = 1'b0;
    tick(12);
    exp_code.push_back(3);
    exp_edge.push_back(e0 + D + 4);
    compare_log("midrst", 1'b1);

    // Long hold: 50 cycles past confirmation (repeats only with the macro)
    press(KEY_UP, D + 50, 10, 1'b0, 1'b0, e0, held);
    expect_press(KEY_UP, D + 50, e0);
    compare_log("longhold", 1'b1);

    // Randomized presses and bounces
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        key_code  = 4'($urandom_range(0, 15));
        key_valid = 1'b1;
        tick($urandom_range(1, D));
        key_valid = 1'b0;
        tick($urandom_range(1, 3));
      end else begin
        code = 4'($urandom_range(0, 15));
        hold = $urandom_range(D + 1, D + 40);
        gap  = $urandom_range(D + 1, D + 6);
        press(code, hold, gap, 1'b0, 1'b0, e0, held);
        expect_press(int'(code), hold, e0);
      end
    end
    tick(D + 10);
    check("rand.overflow", overflow, 0);
    compare_log("rand", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_cmd_ctrl.md
Name: key_cmd_ctrl

Overview:
- Sits between the 4x4 keypad scanner and the maze game logic.
- Debounces the scanner's raw key-valid/key-code pair and emits one command per confirmed press, with optional auto-repeat while a key is held.
- Buffers commands in a small FIFO and hands them to the consumer over a valid/ready handshake; drops and flags commands on overflow.

Parameters:
- DEBOUNCE_CYC, 500000, clk cycles a press or release must be stable (10 ms at 50 MHz); must be ≥2.
- REPEAT_DELAY, 25000000, clk cycles from the first event to the first repeat (REPEAT_EN only).
- REPEAT_PERIOD, 5000000, clk cycles between subsequent repeats (REPEAT_EN only).
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  scanner key-pressed level; asynchronous to clk logic, so it must be synchronised.
- key_code  in  4  scanner key value, 0..15; meaningful only while key_valid=1.
- cmd_ready  in  1  consumer accepts the head command.
- clr_ovf  in  1  synchronous clear of overflow.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  4  head-of-FIFO key code.
- key_held  out  1  high in HELD state.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters 0; FIFO empty.
  - cmd_valid=0, cmd_code=0, key_held=0, overflow=0.
- Synchroniser: key_valid and key_code each pass through 2 flops, giving v_s and c_s. All FSM decisions use v_s and c_s only.
- FSM states: IDLE, DEB, HELD, REL.
  - IDLE: if v_s=1, capture cand=c_s, set cnt=0, go to DEB.
  - DEB:
    - If v_s=0 or c_s≠cand, go to IDLE with no event.
    - Otherwise cnt++.
    - When cnt==DEBOUNCE_CYC-1, push cand, go to HELD, clear the repeat counter.
  - HELD: key_held=1.
    - If v_s=0 or c_s≠cand, go to REL with cnt=0.
    - A changed code counts as a release; the new key needs a fresh press.
  - REL:
    - If v_s=0, cnt++; when cnt==DEBOUNCE_CYC-1, go to IDLE.
    - If v_s=1, reset cnt to 0 and stay in REL.
    - No event is ever pushed from REL.
- Latency: cmd_valid rises exactly DEBOUNCE_CYC+4 clk cycles after the first rising edge at which key_valid is sampled high, provided the FIFO is empty. The budget is 2 sync cycles, the IDLE→DEB cycle, DEBOUNCE_CYC DEB cycles, and 1 FIFO write cycle.
- FIFO:
  - Depth DEPTH; pointers are log2(DEPTH)+1 bits; full and empty are decided on the MSB.
  - Wrap-around is by natural pointer overflow.
  - cmd_code = head entry, valid while cmd_valid=1; it holds its last value when empty.
  - Pop on cmd_valid & cmd_ready.
- FIFO boundary conditions:
  - Push while full with no pop: event dropped, overflow←1, contents unchanged.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only. There is no fall-through; the pop is ignored because cmd_valid=0.
  - clr_ovf=1 clears overflow. If a drop occurs in the same cycle, set wins.
  - cmd_ready while empty: no effect.
- Reset mid-press: FSM returns to IDLE and the FIFO is flushed. A key still held after reset release is re-debounced and generates a fresh event.

Optional Feature:
- Macro: KEY_CMD_REPEAT_EN.
- Defined:
  - In HELD, rcnt counts clk cycles.
  - The first repeat push occurs when rcnt==REPEAT_DELAY-1; rcnt then reloads 0.
  - Later repeats occur every REPEAT_PERIOD cycles.
  - Repeats obey the same overflow rules.
  - Leaving HELD clears rcnt.
- Undefined: rcnt logic is absent; exactly one event per press; REPEAT_* parameters are ignored.

Decomposition:
- Package key_cmd_pkg:
  - state enum {IDLE, DEB, HELD, REL}.
  - KEY_W=4.
  - Maze direction key-code constants KEY_UP=1, KEY_LEFT=4, KEY_RIGHT=6, KEY_DOWN=9 for consumers.
- Sub-module key_cmd_fifo (parameter DEPTH, WIDTH): push/pop, full/empty, drop pulse output. key_cmd_ctrl holds the synchroniser and the FSM.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, DEPTH=4):
- Clean press of code 5 held 30 cycles, cmd_ready=1 → one command 5; cmd_valid rises 8 cycles after first key_valid sample; single-cycle pulse; key_held high during hold.
- Bounce: key_valid high 2 cycles, low 1 cycle, repeated 5 times, then stable low → no command, overflow=0, state back in IDLE.
- cmd_ready=0, five separate clean presses with codes 1, 4, 6, 9, 2 → FIFO holds 1, 4, 6, 9 and overflow=1. Raise cmd_ready → outputs 1, 4, 6, 9 in order, then cmd_valid=0. Pulse clr_ovf → overflow=0.
- Key 6 held, then code switched to 9 without release → only 6 emitted. Release, then press 9 cleanly → 9 emitted.
- reset asserted 3 cycles after a press is confirmed, FIFO non-empty → all outputs 0 immediately. Key still held after reset release → 1 new event after DEBOUNCE_CYC+4 cycles.
- KEY_CMD_REPEAT_EN defined, key 1 held 50 cycles after confirmation → events at confirm+0, +20, +28, +36, +44 (5 total). Macro undefined → 1 event.
